clk_div_multi: RTL



---
 rtl/clk_div_pkg.sv | 18 +
 rtl/clk_div_chan.sv | 65 ++++++
 rtl/clk_div_multi.sv | 92 +++++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared types and helpers for the clk_div_multi divider
package clk_div_pkg;

  localparam int CNT_W_DEF  = 26;
  localparam int CH_MAX_W   = 4;
  localparam int MIN_PERIOD = 2;

  typedef struct packed {
    logic [CH_MAX_W-1:0]  ch;
    logic [CNT_W_DEF-1:0] period;
    logic [CNT_W_DEF-1:0] low;
  } cfg_t;

  function automatic logic [31:0] clamp_period(input logic [31:0] p);
    return (p < 32'(MIN_PERIOD)) ? 32'(MIN_PERIOD) : p;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one divider channel: counter, live period/low, registered outputs
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int               CNT_W      = CNT_W_DEF,
  parameter logic [CNT_W-1:0] RST_PERIOD = CNT_W'(50_000_000),
  parameter logic [CNT_W-1:0] RST_LOW    = CNT_W'(25_000_000)
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             load_i,
  input  logic             sync_i,
  input  logic [CNT_W-1:0] cfg_period_i,
  input  logic [CNT_W-1:0] cfg_low_i,
  output logic             wrap_o,
  output logic             div_out_o,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] low_q, low_d;
  logic             div_q, div_d;
  logic             tick_q, tick_d;

  // Loads only happen at cnt==0 boundaries, so the old low still shapes the last cycle.
  always_comb begin
    wrap_o   = en_i && (cnt_q == period_q - CNT_W'(1));
    cnt_d    = '0;
    div_d    = 1'b0;
    tick_d   = 1'b0;
    period_d = period_q;
    low_d    = low_q;
    if (en_i) begin
      div_d  = (cnt_q >= low_q);
      tick_d = wrap_o && !sync_i;
      cnt_d  = (wrap_o || sync_i) ? '0 : cnt_q + CNT_W'(1);
    end
    if (load_i) begin
      period_d = CNT_W'(clamp_period(32'(cfg_period_i)));
      low_d    = cfg_low_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      period_q <= RST_PERIOD;
      low_q    <= RST_LOW;
      div_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      low_q    <= low_d;
      div_q    <= div_d;
      tick_q   <= tick_d;
    end
  end

  assign div_out_o = div_q;
  assign tick_o    = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel clock divider with config slot; CLK_DIV_SYNC_EN adds sync_in
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int  CH         = 4,
  parameter int  CNT_W      = CNT_W_DEF,
  parameter int  RST_PERIOD = 50_000_000,
  parameter int  RST_LOW    = 25_000_000,
  localparam int CH_W       = (CH > 1) ? $clog2(CH) : 1
)(
  input  logic             clk,
  input  logic             rst,
  input  logic [CH-1:0]    en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_low,
`ifdef CLK_DIV_SYNC_EN
  input  logic             sync_in,
`endif
  output logic [CH-1:0]    div_out,
  output logic [CH-1:0]    tick
);

  localparam int PKG_W = CNT_W_DEF;

  cfg_t          pend_q, pend_d;
  logic          pend_vld_q, pend_vld_d;
  logic          ch_ok, sync, accept;
  logic [CH-1:0] wrap, load;

`ifdef CLK_DIV_SYNC_EN
  assign sync = sync_in;
`else
  assign sync = 1'b0;
`endif

  // Out-of-range channels are swallowed without occupying the slot.
  if (CH == (1 << CH_W)) begin : g_ch_full
    assign ch_ok = 1'b1;
  end else begin : g_ch_part
    assign ch_ok = (cfg_ch < CH_W'(CH));
  end

  assign cfg_ready = !pend_vld_q;
  assign accept    = cfg_valid && cfg_ready && ch_ok;

  always_comb begin
    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
    if (|load) pend_vld_d = 1'b0;
    if (accept) begin
      pend_vld_d    = 1'b1;
      pend_d.ch     = CH_MAX_W'(cfg_ch);
      pend_d.period = PKG_W'(cfg_period);
      pend_d.low    = PKG_W'(cfg_low);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
    end else begin
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_chan
    assign load[g] = pend_vld_q && (pend_q.ch == CH_MAX_W'(g)) && (wrap[g] || !en[g]);

    clk_div_chan #(
      .CNT_W      (CNT_W),
      .RST_PERIOD (CNT_W'(RST_PERIOD)),
      .RST_LOW    (CNT_W'(RST_LOW))
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .en_i         (en[g]),
      .load_i       (load[g]),
      .sync_i       (sync),
      .cfg_period_i (CNT_W'(pend_q.period)),
      .cfg_low_i    (CNT_W'(pend_q.low)),
      .wrap_o       (wrap[g]),
      .div_out_o    (div_out[g]),
      .tick_o       (tick[g])
    );
  end

endmodule
